shared_exp_checker: RTL and testbench
=====================================

Name: shared_exp_checker

Overview:
- Sequential driver/monitor for the shared_exp combinational example, acting as the opposite end of its a..e → q interface.
- Drives all 32 input vectors onto a..e and samples the DUT's q after a programmable settle time.
- Compares each sample against a built-in golden model and reports a pass/fail summary.
- Used in the compiler regression flow to check that optimized netlists of the example remain functionally equivalent.

Parameters:
- SETTLE, 1, number of cycles each vector is held before q_in is sampled; legal range 1..15.
- CW, 4, width of the settle counter; must satisfy 2^CW > SETTLE.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- q_in  input  1  q output of the design under test.
- a  output  1  drive to DUT input a; equals idx[4].
- b  output  1  drive to DUT input b; equals idx[3].
- c  output  1  drive to DUT input c; equals idx[2].
- d  output  1  drive to DUT input d; equals idx[1].
- e  output  1  drive to DUT input e; equals idx[0].
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep finishes.
- pass  output  1  high when the last sweep had zero mismatches; held until the next start.
- err_count  output  6  number of mismatching vectors in the last sweep (0..32).
- fail_valid  output  1  at least one mismatch has been recorded.
- fail_idx  output  5  vector index of the first mismatch.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state = IDLE, idx = 0.
  - a..e, busy, done, pass, fail_valid = 0; err_count = 0; fail_idx = 0.
  - rst takes priority over every other event, including mid-sweep: the sweep is abandoned and no done is produced.
- Golden model: exp = ~a & ~b & d, computed from the registered idx.
  - exp = 1 only for idx ∈ {2, 3, 6, 7}.
- State machine:
  - IDLE → SETTLE on start:
    - idx = 0, settle counter = 1, busy = 1.
    - err_count = 0, fail_valid = 0, fail_idx = 0, pass = 0.
    - a..e present idx 0 from the next cycle.
  - SETTLE: counter increments each cycle; when counter == SETTLE, go to SAMPLE.
  - SAMPLE: compare q_in with exp for the current idx.
    - On mismatch: err_count += 1. If fail_valid = 0, also set fail_idx = idx and fail_valid = 1.
    - If idx == 31, go to DONE.
    - Otherwise idx += 1, counter = 1, go to SETTLE.
  - DONE (exactly one cycle):
    - done = 1, busy = 0, pass = (err_count == 0).
    - Next state is IDLE.
- Timing:
  - Each vector occupies SETTLE + 1 cycles: SETTLE cycles in SETTLE plus 1 cycle in SAMPLE.
  - Latency from the cycle start is sampled to the done pulse is 1 + 32 × (SETTLE + 1) cycles; with SETTLE = 1 that is 65.
  - a..e change only on the SAMPLE → SETTLE transition, so they are stable for the whole vector window.
- Boundary conditions:
  - start while busy, or in the DONE cycle, is ignored.
  - start in the same cycle as rst is ignored.
  - idx does not wrap; the sweep ends at 31.
  - err_count saturates naturally at 32 and fits in 6 bits.
  - Outputs a..e hold the last vector (idx 31 → all 1) in IDLE after a sweep until the next start or reset.
  - pass, err_count and fail_* hold their values through IDLE until the next start.

Test Plan:
- SETTLE = 1; q_in driven by a correct combinational model of a..e; pulse start → busy for 64 cycles, done at cycle 65, pass = 1, err_count = 0, fail_valid = 0.
- q_in tied to 0 → err_count = 4, fail_idx = 2, fail_valid = 1, pass = 0.
- q_in tied to 1 → err_count = 28, fail_idx = 0, pass = 0.
- Assert rst while idx = 10 → next cycle all outputs = 0 and state is IDLE, no done pulse; a fresh start with a correct model → pass = 1.
- Second start pulse at cycle 20 of a sweep → ignored; done still occurs exactly once, at cycle 65.
- SETTLE = 3 with a correct model → done at cycle 129; each vector on a..e held for 4 cycles; pass = 1.

Source files
------------

// File: rtl/shared_exp_checker.sv
// Sweeps all 32 a..e vectors into the shared_exp example and checks q against ~a & ~b & d.
// Reports mismatch count, first failing index and a pass flag after each sweep.
module shared_exp_checker #(
  parameter int SETTLE = 1,
  parameter int CW     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       q_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic       fail_valid,
  output logic [4:0] fail_idx
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state, w_state_next;
  logic [4:0]      r_idx, w_idx_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic            r_busy, w_busy_next;
  logic            r_done, w_done_next;
  logic            r_pass, w_pass_next;
  logic [5:0]      r_err, w_err_next;
  logic            r_fail_valid, w_fail_valid_next;
  logic [4:0]      r_fail_idx, w_fail_idx_next;

  logic            w_exp;
  logic            w_mismatch;
  logic            w_settled;

  assign w_exp      = ~r_idx[4] & ~r_idx[3] & r_idx[1];
  assign w_mismatch = q_in ^ w_exp;
  assign w_settled  = (r_cnt == CW'(SETTLE));

  // State register together with every registered datapath output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_cnt        <= w_cnt_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_pass       <= w_pass_next;
      r_err        <= w_err_next;
      r_fail_valid <= w_fail_valid_next;
      r_fail_idx   <= w_fail_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_SETTLE;
      S_SETTLE: if (w_settled) w_state_next = S_SAMPLE;
      S_SAMPLE: w_state_next = (r_idx == 5'd31) ? S_DONE : S_SETTLE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Results hold through IDLE; they are only cleared by the next accepted start.
  always_comb begin
    w_idx_next        = r_idx;
    w_cnt_next        = r_cnt;
    w_busy_next       = r_busy;
    w_done_next       = 1'b0;
    w_pass_next       = r_pass;
    w_err_next        = r_err;
    w_fail_valid_next = r_fail_valid;
    w_fail_idx_next   = r_fail_idx;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_idx_next        = '0;
          w_cnt_next        = CW'(1);
          w_busy_next       = 1'b1;
          w_pass_next       = 1'b0;
          w_err_next        = '0;
          w_fail_valid_next = 1'b0;
          w_fail_idx_next   = '0;
        end
      end
      S_SETTLE: begin
        if (!w_settled) w_cnt_next = r_cnt + CW'(1);
      end
      S_SAMPLE: begin
        if (w_mismatch) begin
          w_err_next = r_err + 6'd1;
          if (!r_fail_valid) begin
            w_fail_valid_next = 1'b1;
            w_fail_idx_next   = r_idx;
          end
        end
        if (r_idx == 5'd31) begin
          w_busy_next = 1'b0;
        end else begin
          w_idx_next = r_idx + 5'd1;
          w_cnt_next = CW'(1);
        end
      end
      S_DONE: begin
        w_done_next = 1'b1;
        w_busy_next = 1'b0;
        w_pass_next = (r_err == 6'd0);
      end
      default: ;
    endcase
  end

  assign {a, b, c, d, e} = r_idx;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign fail_valid      = r_fail_valid;
  assign fail_idx        = r_fail_idx;

endmodule

// File: tb/tb_shared_exp_checker.sv
// Drives two checker instances (SETTLE=1 and SETTLE=3) against table-driven q_in
// behaviour and compares sweep results with a popcount-based reference.
module tb_shared_exp_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start = 2'b00;
  logic [1:0][31:0] f_tab;
  logic [31:0] gold;

  wire [1:0] q_in, a, b, c, d, e, busy, done, pass, fail_valid;
  wire [1:0][5:0] err_count;
  wire [1:0][4:0] fail_idx;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shared_exp_checker #(.SETTLE(1), .CW(4)) u_dut_s1 (
    .clk(clk), .rst(rst), .start(start[0]), .q_in(q_in[0]),
    .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .e(e[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
    .fail_valid(fail_valid[0]), .fail_idx(fail_idx[0])
  );

  shared_exp_checker #(.SETTLE(3), .CW(4)) u_dut_s3 (
    .clk(clk), .rst(rst), .start(start[1]), .q_in(q_in[1]),
    .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]), .e(e[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
    .fail_valid(fail_valid[1]), .fail_idx(fail_idx[1])
  );

  // q_in is a lookup of the presented vector in a per-instance truth table.
  assign q_in = {f_tab[1][{a[1], b[1], c[1], d[1], e[1]}],
                 f_tab[0][{a[0], b[0], c[0], d[0], e[0]}]};

  function automatic int vec(input int u);
    return int'({a[u], b[u], c[u], d[u], e[u]});
  endfunction

  function automatic int all_outs(input int u);
    return int'({a[u], b[u], c[u], d[u], e[u], busy[u], done[u], pass[u],
                 err_count[u], fail_valid[u], fail_idx[u]});
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full sweep; extra_at >= 0 injects a second start pulse mid-sweep.
  task automatic sweep(input int u, input logic [31:0] f, input int s,
                       input int extra_at, input string tag);
    int dc, bc, bad, nd, errs, fidx, lim, ev;
    logic [31:0] diff;
    diff = f ^ gold;
    errs = $countones(diff);
    fidx = 0;
    for (int i = 31; i >= 0; i--) if (diff[i]) fidx = i;
    f_tab[u] = f;
    @(negedge clk);
    start[u] = 1'b1;
    @(posedge clk);
    #1;
    start[u] = 1'b0;
    dc = -1; bc = 0; bad = 0; nd = 0;
    lim = 32 * (s + 1) + 6;
    for (int k = 0; k < lim; k++) begin
      if (busy[u]) bc++;
      if (done[u]) begin
        nd++;
        if (dc < 0) dc = k;
      end
      ev = k / (s + 1);
      if (ev > 31) ev = 31;
      if (vec(u) != ev) bad++;
      if (k == extra_at) start[u] = 1'b1;
      @(posedge clk);
      #1;
      start[u] = 1'b0;
    end
    check({tag, " done_cycle"}, dc, 1 + 32 * (s + 1));
    check({tag, " busy_cycles"}, bc, 32 * (s + 1));
    check({tag, " done_pulses"}, nd, 1);
    check({tag, " vector_timing_errs"}, bad, 0);
    check({tag, " err_count"}, int'(err_count[u]), errs);
    check({tag, " fail_valid"}, int'(fail_valid[u]), int'(errs != 0));
    check({tag, " fail_idx"}, int'(fail_idx[u]), fidx);
    check({tag, " pass"}, int'(pass[u]), int'(errs == 0));
    $display("sweep %s: f=%08h err_count=%0d fail_idx=%0d pass=%0b done_cycle=%0d",
             tag, f, err_count[u], fail_idx[u], pass[u], dc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nd;
    logic [31:0] fr;
    gold = '0;
    for (int i = 0; i < 32; i++)
      gold[i] = (((i >> 4) & 1) == 0) && (((i >> 3) & 1) == 0) && (((i >> 1) & 1) == 1);
    f_tab[0] = gold;
    f_tab[1] = gold;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_s1", all_outs(0), 0);
    check("reset_outs_s3", all_outs(1), 0);
    $display("reset: outputs s1=%0d s3=%0d", all_outs(0), all_outs(1));
    @(negedge clk);
    rst = 1'b0;

    sweep(0, gold, 1, -1, "s1_correct");
    sweep(0, 32'h0000_0000, 1, -1, "s1_tie0");
    sweep(0, 32'hFFFF_FFFF, 1, -1, "s1_tie1");
    for (int r = 0; r < 3; r++) sweep(0, $urandom, 1, -1, "s1_random");
    for (int r = 0; r < 2; r++) begin
      fr = gold ^ (32'h1 << $urandom_range(31, 0));
      sweep(0, fr, 1, -1, "s1_oneflip");
    end
    sweep(0, gold, 1, 20, "s1_restart");

    // Abort a sweep with reset once vector 10 is on the outputs.
    f_tab[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    k = 0;
    while (vec(0) != 10 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("abort_reach_idx10", vec(0), 10);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_outs_zero", all_outs(0), 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done[0] || busy[0]) nd++;
    end
    check("abort_no_done_or_busy", nd, 0);
    $display("abort: reset at idx 10, done/busy cycles afterwards=%0d", nd);

    // start coinciding with reset must not launch a sweep.
    @(negedge clk);
    rst = 1'b1;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("start_with_rst_busy", int'(busy[0]), 0);
    $display("start_with_rst: busy=%0b", busy[0]);

    sweep(0, gold, 1, -1, "s1_after_abort");
    sweep(1, gold, 3, -1, "s3_correct");
    sweep(1, $urandom, 3, -1, "s3_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
